sub_sat_out_stage: RTL and testbench
====================================

// Module: sub_sat_out_stage
// PURPOSE
//  Registered output stage downstream of the 32-bit signed subtractor. Consumes result/overflow per beat,
//  saturates on overflow (or passes wrapped value through), and presents it on a valid/ready stream.
//  A 2-entry skid buffer gives full throughput under backpressure. Keeps a sticky overflow flag for software.
// PARAMETERS
//  WIDTH     32  data width of subtractor result (signed, two's complement)
//  SAT_MODE  1   1 = clamp to SMAX/SMIN on overflow; 0 = pass wrapped result, still flag
//  CNT_W     16  width of overflow event counter (SUB_OVF_COUNT_EN only)
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        upstream beat valid
//  in_ready     out  1        stage can accept a beat
//  in_result    in   WIDTH    subtractor result (A-B, wrapped)
//  in_overflow  in   1        subtractor signed-overflow flag
//  out_valid    out  1        output beat valid
//  out_ready    in   1        downstream accepts
//  out_data     out  WIDTH    saturated/wrapped result
//  out_sat      out  1        beat had overflow (clamped when SAT_MODE=1)
//  sticky_ovf   out  1        set by any accepted overflow beat; held until clr_sticky
//  clr_sticky   in   1        clear sticky_ovf (and ovf_count)
//  ovf_count    out  CNT_W    accepted overflow beats, saturating; 0 without SUB_OVF_COUNT_EN
// BEHAVIOUR
//  - Reset: in_ready=0 during rst, 1 cycle after; out_valid=0, out_data=0, out_sat=0, sticky_ovf=0, ovf_count=0.
//  - Transfer on in_valid&&in_ready (accept) / out_valid&&out_ready (emit). Accepted beat visible on out_* next cycle (latency 1).
//  - Saturation: if in_overflow && SAT_MODE: in_result[WIDTH-1]==1 -> SMAX (0x7FFF_FFFF), else SMIN (0x8000_0000).
//    Overflow without SAT_MODE: data=in_result unchanged, out_sat=1. No overflow: data=in_result, out_sat=0.
//  - Buffer: 2 entries, occupancy 0/1/2. in_ready = (occ<2). Order strictly FIFO; no beat dropped or duplicated.
//    occ=2 and out_ready=0 -> in_ready=0, out_* held stable. Accept+emit same cycle -> occ unchanged.
//  - out_data/out_sat stable while out_valid && !out_ready (AXI-style; valid never retracted).
//  - sticky_ovf: set on accept of overflow beat; clr_sticky clears; simultaneous set+clear -> set wins (result 1).
//  - ovf_count: +1 per accepted overflow beat, stops at 2^CNT_W-1; clr_sticky zeroes; simultaneous -> value 1.
//  - Reset mid-stream: all buffered beats discarded, no out_valid the cycle after rst deasserts.
//  - States (occupancy FSM): EMPTY -accept-> ONE; ONE -accept&!emit-> TWO; ONE -emit&!accept-> EMPTY;
//    TWO -emit-> ONE (no accept possible in TWO). Any state -rst-> EMPTY.
// CONFIGURATION
//  SUB_OVF_COUNT_EN defined: counter implemented as above.
//  Not defined: no counter logic; ovf_count tied to 0; all other behaviour identical.
// STRUCTURE
//  Package sub_pkg: WIDTH default constant, SMAX/SMIN localparams as function of WIDTH,
//   typedef struct packed {logic [WIDTH-1:0] data; logic sat;} sub_beat_t, sat_clamp() function.
//  Sub-module sub_skid_buf: generic 2-entry valid/ready buffer of sub_beat_t; top does clamp + flags/counter.
// TESTING
//  1. in_result=0x8000_0000, ovf=1 (A=2147483647,B=-1), SAT_MODE=1 -> out_data=0x7FFF_FFFF, out_sat=1, sticky_ovf=1.
//  2. in_result=0x7FFF_FFFF, ovf=1 (A=-2147483648,B=1) -> out_data=0x8000_0000; SAT_MODE=0 -> 0x7FFF_FFFF, out_sat=1.
//  3. Stream 5,-3,0 with out_ready=1 -> same order, one per cycle, latency 1, out_sat=0.
//  4. out_ready=0, push 3 beats -> in_ready drops after 2; release -> beats 1,2,3 in order, none lost.
//  5. Overflow beat accepted same cycle as clr_sticky -> sticky_ovf=1, ovf_count=1 (macro on) / 0 (off).
//  6. rst asserted with occ=2 -> next cycle out_valid=0, sticky_ovf=0, ovf_count=0; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and helpers for the subtractor output stage.
// Beat layout, saturation limits and the overflow clamp function.
package sub_pkg;

  localparam int unsigned SubWidth = 32;

  localparam logic [SubWidth-1:0] SMAX = {1'b0, {(SubWidth - 1) {1'b1}}};
  localparam logic [SubWidth-1:0] SMIN = {1'b1, {(SubWidth - 1) {1'b0}}};

  typedef struct packed {
    logic [SubWidth-1:0] data;
    logic                sat;
  } sub_beat_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } occ_state_e;

  // A wrapped negative result means the true difference was too large, and vice versa.
  function automatic sub_beat_t sat_clamp(input logic [SubWidth-1:0] result,
                                          input logic                overflow,
                                          input logic                sat_mode);
    sub_beat_t beat;
    beat.data = result;
    beat.sat  = overflow;
    if (overflow && sat_mode) begin
      beat.data = result[SubWidth-1] ? SMAX : SMIN;
    end
    return beat;
  endfunction

endpackage

// File: rtl/sub_skid_buf.sv
// Two-entry valid/ready buffer of sub_beat_t with strict FIFO ordering.
// Occupancy is tracked by a three-process FSM; the head entry drives the output.
module sub_skid_buf
  import sub_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  sub_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output sub_beat_t out_beat
);

  occ_state_e state_q, state_d;
  sub_beat_t  head_q, head_d;
  sub_beat_t  tail_q, tail_d;

  logic push;
  logic pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop) begin
          state_d = StTwo;
        end else if (pop && !push) begin
          state_d = StEmpty;
        end
      end
      StTwo:   if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
    out_beat  = head_q;
  end

  // Head only changes when it is empty, being popped, or refilled from the tail.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      StEmpty: if (push) head_d = in_beat;
      StOne: begin
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d = in_beat;
        end
      end
      StTwo:   if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && (out_beat == $past(out_beat)));

  assert property (@(posedge clk) disable iff (rst)
    (state_q == StTwo) |-> !push);

endmodule

// File: rtl/sub_sat_out_stage.sv
// Registered output stage for the signed subtractor: clamp, skid buffer, sticky flag.
// Define SUB_OVF_COUNT_EN to build the saturating overflow event counter.
module sub_sat_out_stage
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH    = SubWidth,
  parameter bit          SAT_MODE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  sub_beat_t in_beat;
  sub_beat_t out_beat;
  logic      buf_ready;
  logic      ready_q;
  logic      accept;
  logic      accept_ovf;
  logic      sticky_q, sticky_d;

  // Held low through reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign in_ready   = buf_ready && ready_q && !rst;
  assign accept     = in_valid && in_ready;
  assign accept_ovf = accept && in_overflow;
  assign in_beat    = sat_clamp(in_result, in_overflow, SAT_MODE);

  sub_skid_buf u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid && in_ready),
    .in_ready (buf_ready),
    .in_beat  (in_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_beat (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_sat  = out_beat.sat;

  always_comb begin
    sticky_d = clr_sticky ? 1'b0 : sticky_q;
    if (accept_ovf) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;

`ifdef SUB_OVF_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Clear first, then count, so a simultaneous clear and overflow leaves one event.
  always_comb begin
    count_d = clr_sticky ? '0 : count_q;
    if (accept_ovf && (count_d != {CNT_W{1'b1}})) begin
      count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ovf_count = count_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_sub_sat_out_stage.sv
// Self-checking bench for sub_sat_out_stage: vector table, directed corners, random stream.
// Two instances run in lockstep: SAT_MODE=1 with a 16-bit counter, SAT_MODE=0 with a 2-bit one.
module tb_sub_sat_out_stage;

`ifdef SUB_OVF_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        out_ready;
  logic        clr_sticky;

  logic        in_ready, out_valid, out_sat, sticky_ovf;
  logic [31:0] out_data;
  logic [15:0] ovf_count;
  logic        in_ready0, out_valid0, out_sat0, sticky_ovf0;
  logic [31:0] out_data0;
  logic [1:0]  ovf_count0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_sat_out_stage #(.WIDTH(32), .SAT_MODE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .ovf_count(ovf_count)
  );

  sub_sat_out_stage #(.WIDTH(32), .SAT_MODE(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_result(in_result), .in_overflow(in_overflow), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0),
    .sticky_ovf(sticky_ovf0), .clr_sticky(clr_sticky), .ovf_count(ovf_count0)
  );

  // Reference model: a FIFO of expected beats plus flag/counter values.
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic [31:0] e1;
    logic [31:0] e0;
  } vec_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] obs[$];
  bit          ready_flag = 1'b0;
  bit          sticky = 1'b0;
  int          cnt1 = 0;
  int          cnt0 = 0;
  bit          acc_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !rst && ready_flag && (q.size() < 2);
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, exp_ready());
    chk("in_ready0", in_ready0, exp_ready());
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_valid0", out_valid0, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d1);
      chk("out_data0", out_data0, q[0].d0);
      chk("out_sat", out_sat, q[0].sat);
      chk("out_sat0", out_sat0, q[0].sat);
    end
    chk("sticky_ovf", sticky_ovf, sticky);
    chk("sticky_ovf0", sticky_ovf0, sticky);
    chk("ovf_count", ovf_count, CntEn ? cnt1 : 0);
    chk("ovf_count0", ovf_count0, CntEn ? cnt0 : 0);
  endtask

  task automatic drive(input logic [31:0] res, input logic ovf,
                       input logic [31:0] e1, input logic [31:0] e0);
    in_result   = res;
    in_overflow = ovf;
    cur.d1      = e1;
    cur.d0      = e0;
    cur.sat     = ovf;
  endtask

  // One clock: check at negedge, update the model at posedge, return 1 time unit later.
  task automatic tick();
    bit acc;
    bit emi;
    @(negedge clk);
    check_outputs();
    acc = in_valid && exp_ready();
    emi = (q.size() > 0) && out_ready;
    if (out_valid && out_ready) obs.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      q.delete();
      sticky     = 1'b0;
      cnt1       = 0;
      cnt0       = 0;
      ready_flag = 1'b0;
    end else begin
      ready_flag = 1'b1;
      if (emi) void'(q.pop_front());
      if (acc) q.push_back(cur);
      if (clr_sticky) begin
        sticky = 1'b0;
        cnt1   = 0;
        cnt0   = 0;
      end
      if (acc && in_overflow) begin
        sticky = 1'b1;
        if (cnt1 < 65535) cnt1++;
        if (cnt0 < 3) cnt0++;
      end
    end
    acc_last = acc;
    #1;
  endtask

  task automatic rand_beat();
    int signed   a;
    int signed   b;
    longint      diff;
    logic [63:0] d64;
    bit          ovf;
    logic [31:0] sat_v;
    int          pick;
    a = $urandom;
    b = $urandom;
    pick = $urandom_range(0, 7);
    if (pick == 0) a = 32'sh7FFF_FFFF;
    if (pick == 1) a = 32'sh8000_0000;
    if (pick == 2) b = -1;
    if (pick == 3) b = 32'sh7FFF_FFFF;
    diff = longint'(a) - longint'(b);
    d64  = diff;
    ovf  = (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
    if (diff > 64'sd2147483647) begin
      sat_v = 32'h7FFF_FFFF;
    end else if (diff < -64'sd2147483648) begin
      sat_v = 32'h8000_0000;
    end else begin
      sat_v = d64[31:0];
    end
    drive(d64[31:0], ovf, sat_v, d64[31:0]);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{res: 32'h8000_0000, ovf: 1'b1, e1: 32'h7FFF_FFFF, e0: 32'h8000_0000};
    vecs[1] = '{res: 32'h7FFF_FFFF, ovf: 1'b1, e1: 32'h8000_0000, e0: 32'h7FFF_FFFF};
    vecs[2] = '{res: 32'd5,         ovf: 1'b0, e1: 32'd5,         e0: 32'd5};
    vecs[3] = '{res: 32'hFFFF_FFFD, ovf: 1'b0, e1: 32'hFFFF_FFFD, e0: 32'hFFFF_FFFD};
    vecs[4] = '{res: 32'd0,         ovf: 1'b0, e1: 32'd0,         e0: 32'd0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    tick();
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Vector table: one beat per cycle, visible the cycle after acceptance.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].res, vecs[i].ovf, vecs[i].e1, vecs[i].e0);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].e1);
      chk($sformatf("vec%0d_data0", i), out_data0, vecs[i].e0);
      chk($sformatf("vec%0d_sat", i), out_sat, vecs[i].ovf);
    end
    chk("vec_sticky", sticky_ovf, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // Backpressure: third beat stalls until the buffer drains; order preserved.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'd11, 1'b0, 32'd11, 32'd11);
    tick();
    drive(32'd22, 1'b0, 32'd22, 32'd22);
    tick();
    drive(32'd33, 1'b0, 32'd33, 32'd33);
    chk("bp_in_ready_full", in_ready, 1'b0);
    tick();
    chk("bp_hold_data", out_data, 32'd11);
    chk("bp_hold_ready", in_ready, 1'b0);
    obs.delete();
    out_ready = 1'b1;
    acc_last  = 1'b0;
    for (int i = 0; i < 8 && !acc_last; i++) tick();
    chk("bp_third_accepted", acc_last, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    tick();
    chk("bp_obs_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("bp_obs0", obs[0], 32'd11);
      chk("bp_obs1", obs[1], 32'd22);
      chk("bp_obs2", obs[2], 32'd33);
    end

    // Overflow beat accepted together with clr_sticky: set wins.
    in_valid   = 1'b1;
    clr_sticky = 1'b1;
    drive(32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    tick();
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    chk("clr_set_sticky", sticky_ovf, 1'b1);
    chk("clr_set_count", ovf_count, CntEn ? 16'd1 : 16'd0);
    chk("clr_set_count0", ovf_count0, CntEn ? 2'd1 : 2'd0);
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_sticky", sticky_ovf, 1'b0);

    // Two-bit counter in dut0 saturates at 3.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
      tick();
    end
    in_valid = 1'b0;
    chk("cnt0_saturate", ovf_count0, CntEn ? 2'd3 : 2'd0);
    chk("cnt1_five", ovf_count, CntEn ? 16'd5 : 16'd0);
    tick();

    // Reset with two beats buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'd7, 1'b1, 32'h8000_0000, 32'd7);
    tick();
    drive(32'd8, 1'b0, 32'd8, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sticky", sticky_ovf, 1'b0);
    chk("mid_rst_count", ovf_count, 16'd0);
    chk("mid_rst_ready_low", in_ready, 1'b0);
    tick();
    chk("mid_rst_ready_high", in_ready, 1'b1);
    chk("mid_rst_still_empty", out_valid, 1'b0);

    // Random stream against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      rand_beat();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
